q_vector_gather: RTL and testbench
==================================

// Module: q_vector_gather
// PURPOSE
//  Upstream feeder for the combinational quantized neuron stage.
//  - Collects a serial stream of signed int8 activations into N_INPUTS-wide vectors.
//  - Presents each completed vector with a valid/ready handshake.
//  - Ping-pong (2-bank) buffering lets the next vector fill while the current one is consumed.
//  - Frame markers are checked; short frames are padded so the neuron always sees N_INPUTS lanes.
// PARAMETERS
//  N_INPUTS   8  lanes per output vector (>=2); must match the downstream neuron stage
//  PAD_VALUE  0  signed int8 written to lanes left unfilled by a short frame
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst_n      in   1         asynchronous active-low reset
//  clear      in   1         synchronous flush of all buffered data and lane count
//  s_data     in   8 s       input activation byte
//  s_valid    in   1         s_data valid
//  s_last     in   1         s_data is the final byte of the current vector
//  s_ready    out  1         gatherer can accept s_data this cycle
//  m_data     out  8 s x N_INPUTS  assembled vector; lane 0 = first byte received
//  m_valid    out  1         m_data holds a complete vector
//  m_ready    in   1         downstream accepts m_data
//  err_short  out  1         1-cycle pulse: s_last came before lane N_INPUTS-1; vector padded
//  err_nolast out  1         1-cycle pulse: lane N_INPUTS-1 written without s_last
// BEHAVIOUR
//  State
//  - bank[2][N_INPUTS] int8; full[2]; wr_sel; rd_sel; lane counter 0..N_INPUTS-1.
//  Reset values
//  - full=0, wr_sel=rd_sel=0, lane=0, banks=0.
//  - m_valid=0, m_data=0 (rd bank contents), err_*=0.
//  - s_ready=1 once rst_n is released.
//  Input handshake
//  - Byte accepted iff s_valid && s_ready.
//  - s_ready = !full[wr_sel]; combinational from registers, never from s_valid.
//  - Accepted byte goes to bank[wr_sel][lane]; lane increments.
//  Vector completion (on acceptance)
//  - Completes when lane==N_INPUTS-1 OR s_last=1.
//  - On completion: full[wr_sel]<=1, wr_sel toggles, lane<=0.
//  - s_last at lane k<N_INPUTS-1:
//    - lanes k+1..N_INPUTS-1 <= PAD_VALUE in the same cycle;
//    - err_short pulses next cycle.
//  - lane==N_INPUTS-1 with s_last=0: vector still completes; err_nolast pulses next cycle.
//  - Following bytes start a new vector.
//  Output handshake
//  - m_valid = full[rd_sel]; m_data = bank[rd_sel].
//  - Latency: m_valid rises the cycle after the completing byte is accepted.
//  - While m_valid && !m_ready: m_data and m_valid held stable.
//  - m_valid && m_ready: full[rd_sel]<=0, rd_sel toggles.
//  Boundary cases
//  - Both banks full: s_ready=0; input stalls until a vector is consumed.
//  - Both banks empty: m_valid=0.
//  - Consume and complete in the same cycle, including on the same bank index:
//    - both updates apply;
//    - throughput is 1 vector per N_INPUTS cycles with no bubble.
//  - clear=1 has priority over every handshake that cycle:
//    - full=0, lane=0, wr_sel=rd_sel=0, no err pulses;
//    - partially filled vector discarded; bank contents need not be zeroed.
//  - Reset mid-frame: all state returns to reset values; no partial vector survives.
//  Arithmetic
//  - No arithmetic on data; bytes pass through bit-exact, sign preserved.
//  - Lane counter width $clog2(N_INPUTS); it never exceeds N_INPUTS-1.
// TESTING
//  1. N=8, stream 1..8, s_last on 8th, m_ready=1
//     -> m_data={1..8} one cycle after 8th byte; no err pulses.
//  2. Bytes -5,7,-128 with s_last on 3rd, PAD_VALUE=0
//     -> m_data={-5,7,-128,0,0,0,0,0}; err_short one pulse.
//  3. m_ready=0, stream 3 full vectors
//     -> s_ready drops after 16 bytes; vectors exit in order, intact, once m_ready=1.
//  4. 8 bytes with no s_last, then 8 more with s_last
//     -> two vectors; err_nolast pulses once, after the first.
//  5. clear asserted after 5 bytes, then 8 new bytes
//     -> only the new vector is emitted; lanes 0..7 = new bytes.
//  6. rst_n low mid-frame with one full bank pending
//     -> m_valid=0, s_ready=1 after release; next vector starts at lane 0.

Source files
------------

// File: rtl/q_vector_gather.sv
// Serial int8 activation gatherer: packs a byte stream into N_INPUTS-lane vectors
// through a two-bank ping-pong buffer, padding short frames and flagging framing errors.
module q_vector_gather #(
  parameter int                 N_INPUTS  = 8,
  parameter logic signed [7:0]  PAD_VALUE = 8'sd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [N_INPUTS*8-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    err_short,
  output logic                    err_nolast
);

  localparam int             LW        = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [LW-1:0]  LAST_LANE = LW'(N_INPUTS - 1);

  logic [7:0]     bank_q [2][N_INPUTS];
  logic [7:0]     bank_d [2][N_INPUTS];
  logic [1:0]     full_q, full_d;
  logic           wr_sel_q, wr_sel_d;
  logic           rd_sel_q, rd_sel_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic           err_short_q, err_short_d;
  logic           err_nolast_q, err_nolast_d;

  logic           s_acc_s;
  logic           m_acc_s;
  logic           complete_s;

  // Handshake outputs are decoded straight from registered state.
  always_comb begin
    s_ready    = ~full_q[wr_sel_q];
    m_valid    = full_q[rd_sel_q];
    err_short  = err_short_q;
    err_nolast = err_nolast_q;
    m_data     = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      m_data[i*8 +: 8] = bank_q[rd_sel_q][i];
    end
  end

  // Next-state: bank writes with padding, bank occupancy, pointers and error pulses.
  always_comb begin
    bank_d       = bank_q;
    full_d       = full_q;
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    lane_d       = lane_q;
    err_short_d  = 1'b0;
    err_nolast_d = 1'b0;

    s_acc_s    = s_valid & ~full_q[wr_sel_q];
    m_acc_s    = full_q[rd_sel_q] & m_ready;
    complete_s = s_acc_s & ((lane_q == LAST_LANE) | s_last);

    if (clear) begin
      full_d   = 2'b00;
      wr_sel_d = 1'b0;
      rd_sel_d = 1'b0;
      lane_d   = '0;
    end else begin
      // Consume is applied before complete so both land when they hit the same cycle.
      if (m_acc_s) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end else begin
        rd_sel_d = rd_sel_q;
      end

      if (s_acc_s) begin
        for (int i = 0; i < N_INPUTS; i++) begin
          if (LW'(i) == lane_q) begin
            bank_d[wr_sel_q][i] = s_data;
          end else if (s_last && (LW'(i) > lane_q)) begin
            bank_d[wr_sel_q][i] = PAD_VALUE;
          end else begin
            bank_d[wr_sel_q][i] = bank_q[wr_sel_q][i];
          end
        end

        if (complete_s) begin
          full_d[wr_sel_q] = 1'b1;
          wr_sel_d         = ~wr_sel_q;
          lane_d           = '0;
          err_short_d      = s_last & (lane_q != LAST_LANE);
          err_nolast_d     = ~s_last & (lane_q == LAST_LANE);
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end else begin
        lane_d = lane_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_INPUTS; i++) begin
          bank_q[b][i] <= 8'h00;
        end
      end
      full_q       <= 2'b00;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      lane_q       <= '0;
      err_short_q  <= 1'b0;
      err_nolast_q <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      full_q       <= full_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      lane_q       <= lane_d;
      err_short_q  <= err_short_d;
      err_nolast_q <= err_nolast_d;
    end
  end

endmodule

// File: tb/tb_q_vector_gather.sv
// Scoreboard bench for q_vector_gather: a frame-level reference model queues expected
// vectors and error pulses; a negedge monitor compares them with what the DUT presents.
module tb_q_vector_gather;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear = 1'b0;
  logic [7:0]     s_data = 8'h00;
  logic           s_valid = 1'b0;
  logic           s_last = 1'b0;
  logic           m_ready = 1'b0;
  logic           s_ready, m_valid, err_short, err_nolast;
  logic [N*8-1:0] m_data;

  int checks = 0;
  int errors = 0;
  bit rand_mode = 1'b0;

  logic [N*8-1:0] exp_q[$];
  logic [7:0]     cur[$];
  bit             pend_short = 1'b0;
  bit             pend_nolast = 1'b0;

  q_vector_gather #(.N_INPUTS(N), .PAD_VALUE(8'sd0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .err_short(err_short), .err_nolast(err_nolast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N*8-1:0] act, input logic [N*8-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and monitor: everything sampled at negedge, where it is stable.
  initial begin
    logic [N*8-1:0] v;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        cur.delete();
        pend_short  = 1'b0;
        pend_nolast = 1'b0;
        chk("reset_m_valid", {63'd0, m_valid}, 64'd0);
        chk("reset_m_data", m_data, 64'd0);
        chk("reset_err", {62'd0, err_short, err_nolast}, 64'd0);
      end else begin
        chk("err_short", {63'd0, err_short}, {63'd0, pend_short});
        chk("err_nolast", {63'd0, err_nolast}, {63'd0, pend_nolast});
        chk("m_valid", {63'd0, m_valid}, {63'd0, exp_q.size() != 0});
        chk("s_ready", {63'd0, s_ready}, {63'd0, exp_q.size() < 2});
        if (m_valid && exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
        pend_short  = 1'b0;
        pend_nolast = 1'b0;
        if (clear) begin
          exp_q.delete();
          cur.delete();
        end else begin
          if (m_valid && m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
          if (s_valid && s_ready) begin
            cur.push_back(s_data);
            if (cur.size() == N || s_last) begin
              pend_short  = (cur.size() < N);
              pend_nolast = (cur.size() == N) && !s_last;
              v = '0;
              for (int i = 0; i < cur.size(); i++) v[i*8 +: 8] = cur[i];
              exp_q.push_back(v);
              cur.delete();
            end
          end
        end
      end
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) m_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic send(input logic [7:0] d, input bit l);
    bit ok = 1'b0;
    s_data = d; s_last = l; s_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got no s_ready expected acceptance of %h", d);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // 1: full vector 1..8 with s_last on the 8th
    m_ready = 1'b1;
    for (int i = 1; i <= N; i++) send(8'(i), i == N);
    idle(3);

    // 2: short frame padded
    send(8'hFB, 1'b0); send(8'h07, 1'b0); send(8'h80, 1'b1);
    idle(3);

    // 3: backpressure over three vectors
    m_ready = 1'b0;
    fork
      for (int i = 0; i < 3 * N; i++) send(8'(i * 7 + 3), (i % N) == N - 1);
      begin idle(40); m_ready = 1'b1; end
    join
    idle(4);

    // 4: missing s_last then a proper frame
    for (int i = 0; i < 2 * N; i++) send(8'(8'hA0 + i), i == 2 * N - 1);
    idle(3);

    // 5: clear after five bytes
    for (int i = 0; i < 5; i++) send(8'(8'h50 + i), 1'b0);
    clear = 1'b1; idle(1); clear = 1'b0;
    for (int i = 0; i < N; i++) send(8'(8'hC0 + i), i == N - 1);
    idle(3);

    // 6: reset mid-frame with a bank pending
    m_ready = 1'b0;
    for (int i = 0; i < N; i++) send(8'(8'h10 + i), i == N - 1);
    for (int i = 0; i < 3; i++) send(8'(8'h90 + i), 1'b0);
    rst_n = 1'b0; idle(2); rst_n = 1'b1;
    idle(1);
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) send(8'(8'h20 + i), i == N - 1);
    idle(3);

    // 7: random traffic with backpressure, gaps and occasional clear
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 60) == 0) begin clear = 1'b1; idle(1); clear = 1'b0; end
    end
    rand_mode = 1'b0;
    idle(1);
    m_ready = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
